pci_arbiter: RTL

Central PCI bus arbiter sitting upstream of every PCI_DEV instance: it samples each device's REQ line and drives the per-device GNT line that the device's master/slave selection consumes. Arbitration is round-robin fair. Grant changes only across an idle bus, with at least one dead cycle between owners. A timeout reclaims grants from masters that never start a transaction.

---
 rtl/pci_arbiter_if.sv | 25 ++
 rtl/pci_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pci_arbiter_if.sv
// Arbiter bus bundle: active-low per-device REQ/GNT, shared FRAME/IRDY, arbiter status.
// master: arbiter side; samples req/frame/irdy, drives gnt and status flags.
// slave:  device/bus side; drives req/frame/irdy, observes gnt and status flags.
interface pci_arbiter_if #(
    parameter int N_DEV = 4
);
    logic [N_DEV-1:0] req;          // per-device request, 0 = requesting
    logic             frame;        // shared FRAME, active-low
    logic             irdy;         // shared IRDY, active-low
    logic [N_DEV-1:0] gnt;          // per-device grant, at most one bit low
    logic [2:0]       owner;        // granted device index, meaningful when owner_valid
    logic             owner_valid;  // any gnt bit low
    logic             bus_busy;     // granted master has started a transaction
    logic             timeout_err;  // one-cycle pulse on grant revoked by timeout

    modport master (
        input  req, frame, irdy,
        output gnt, owner, owner_valid, bus_busy, timeout_err
    );

    modport slave (
        output req, frame, irdy,
        input  gnt, owner, owner_valid, bus_busy, timeout_err
    );
endinterface

// File: rtl/pci_arbiter.sv
// Round-robin PCI bus arbiter with idle-bus handover, a dead cycle between owners, grant timeout.
// Latency: an input sampled at edge k acts on the outputs after edge k+1 (input stage + FSM flop).
// Backpressure: none; requests simply wait in REQ until the round-robin search reaches them.
// Ports: clk, rst_n (async active-low); bus (master modport): req/frame/irdy in,
//        gnt/owner/owner_valid/bus_busy/timeout_err out, all driven straight from flops.
module pci_arbiter #(
    parameter int N_DEV   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pci_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

    localparam logic [4:0] T_LAST = 5'(TIMEOUT - 1);

    state_t           state, state_n;
    logic [2:0]       last, last_n;
    logic [2:0]       owner_q, owner_n;
    logic [4:0]       timer, timer_n;
    logic [N_DEV-1:0] gnt_q, gnt_n;
    logic             ov_q, ov_n;
    logic             busy_q, busy_n;
    logic             terr_q, terr_n;

    // Bus inputs are registered once before the FSM sees them.
    logic [N_DEV-1:0] req_s;
    logic             frame_s, irdy_s;

    logic [7:0]       req_ext;   // non-existent devices read as not requesting
    logic [7:0]       sel_ext;   // grant pattern for the search winner
    logic [3:0]       cand;
    logic [2:0]       pick;
    logic             pick_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s   <= '1;
            frame_s <= 1'b1;
            irdy_s  <= 1'b1;
        end else begin
            req_s   <= bus.req;
            frame_s <= bus.frame;
            irdy_s  <= bus.irdy;
        end
    end

    always_comb begin
        req_ext            = 8'hFF;
        req_ext[N_DEV-1:0] = req_s;
    end

    // Search LAST+1, LAST+2, ... modulo N_DEV; first requester wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = 1; i <= N_DEV; i++) begin
            cand = {1'b0, last} + 4'(i);
            if (cand >= 4'(N_DEV)) begin
                cand = cand - 4'(N_DEV);
            end
            if (!pick_vld && !req_ext[cand[2:0]]) begin
                pick_vld = 1'b1;
                pick     = cand[2:0];
            end
        end
    end

    always_comb begin
        sel_ext       = 8'hFF;
        sel_ext[pick] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= 3'(N_DEV - 1);
            owner_q <= '0;
            timer   <= '0;
            gnt_q   <= '1;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            owner_q <= owner_n;
            timer   <= timer_n;
            gnt_q   <= gnt_n;
            ov_q    <= ov_n;
            busy_q  <= busy_n;
            terr_q  <= terr_n;
        end
    end

    // owner_q doubles as the registered winner W while in GRANT/BUSY.
    always_comb begin
        state_n = state;
        last_n  = last;
        owner_n = owner_q;
        timer_n = timer;
        gnt_n   = gnt_q;
        ov_n    = ov_q;
        busy_n  = busy_q;
        terr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_n = GRANT;
                    last_n  = pick;
                    owner_n = pick;
                    timer_n = '0;
                    gnt_n   = sel_ext[N_DEV-1:0];
                    ov_n    = 1'b1;
                end
            end
            GRANT: begin
                // FRAME beats REQ release, which beats the timeout.
                if (!frame_s) begin
                    state_n = BUSY;
                    busy_n  = 1'b1;
                end else if (req_ext[owner_q] || timer == T_LAST) begin
                    state_n = IDLE;
                    gnt_n   = '1;
                    ov_n    = 1'b0;
                    owner_n = '0;
                    terr_n  = !req_ext[owner_q];
                end else if (timer != 5'h1F) begin
                    timer_n = timer + 5'd1;
                end
            end
            BUSY: begin
                if (frame_s && irdy_s) begin
                    state_n = IDLE;
                    gnt_n   = '1;
                    ov_n    = 1'b0;
                    owner_n = '0;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.gnt         = gnt_q;
    assign bus.owner       = owner_q;
    assign bus.owner_valid = ov_q;
    assign bus.bus_busy    = busy_q;
    assign bus.timeout_err = terr_q;
endmodule
